// File: rtl/mb_seq_mult_ctrl.sv
// Sequential signed radix-4 Modified Booth multiplier: one Booth digit per cycle
// through a single shared partial-product generator, with a start/busy/done handshake.
module mb_seq_mult_ctrl #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   product
);

  localparam int         DIGITS = W / 2;
  localparam logic [1:0] LAST_J = 2'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic signed [W-1:0]   a_q, a_d;
  logic        [W-1:0]   b_q, b_d;
  logic        [1:0]     j_q, j_d;
  logic signed [2*W-1:0] acc_q, acc_d;
  logic signed [2*W-1:0] product_q, product_d;

  logic        [W:0]     b_ext;
  logic        [2:0]     trip;
  logic                  one_j, two_j, sign_j;
  logic        [W:0]     pp_raw;
  logic signed [W:0]     pp_true;
  logic signed [2*W-1:0] pp_ext, term, sum;
  logic        [2:0]     shamt;

  // Shared partial-product generator; its MSB leaves inverted.
  function automatic logic [W:0] pp_mb_gen(input logic [W-1:0] mcand,
                                           input logic sel_one,
                                           input logic sel_two,
                                           input logic neg);
    logic [W:0] x1, x2, r;
    x1 = {mcand[W-1], mcand};
    x2 = {mcand, 1'b0};
    r  = (({(W+1){sel_one}} & x1) | ({(W+1){sel_two}} & x2)) ^ {(W+1){neg}};
    r[W] = ~r[W];
    return r;
  endfunction

  always_comb begin
    b_ext   = {b_q, 1'b0};
    trip    = b_ext[{j_q, 1'b0} +: 3];
    one_j   = trip[1] ^ trip[0];
    two_j   = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);
    sign_j  = trip[2];
    pp_raw  = pp_mb_gen(a_q, one_j, two_j, sign_j);
    pp_true = {~pp_raw[W], pp_raw[W-1:0]};
    pp_ext  = {{(W-1){pp_true[W]}}, pp_true};
    shamt   = {j_q, 1'b0};
    // sign_j << 2j completes the ones'-complement negation into two's complement.
    term    = (pp_ext <<< shamt) + ((2*W)'(sign_j) << shamt);
    sum     = acc_q + term;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    j_d       = j_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = sum;
        j_d   = j_q + 2'd1;
        if (j_q == LAST_J) begin
          product_d = sum;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      j_q       <= j_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mb_seq_mult_ctrl.sv
// Directed and random checks of the sequential Booth multiplier controller.
module tb_mb_seq_mult_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int vec_count;
  int miss_count;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  mb_seq_mult_ctrl #(.W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation with start for one cycle; checks handshake timing and result.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                        input logic [15:0] exp, input bit full_check);
    start = 1'b1;
    a     = va;
    b     = vb;
    tick();
    start = 1'b0;
    a     = ~va;
    b     = ~vb;
    for (int i = 0; i < 4; i++) begin
      if (full_check) chk("busy_run", {15'd0, busy}, 16'd1);
      if (full_check) chk("done_run", {15'd0, done}, 16'd0);
      tick();
    end
    chk("done_pulse", {15'd0, done}, 16'd1);
    if (full_check) chk("busy_done", {15'd0, busy}, 16'd0);
    chk("product", product, exp);
    tick();
    if (full_check) chk("done_low", {15'd0, done}, 16'd0);
    if (full_check) chk("product_hold", product, exp);
  endtask

  initial begin
    logic signed [7:0]  ra, rb;
    logic signed [15:0] rexp;
    vec_count  = 0;
    miss_count = 0;

    vecs[0] = '{8'd3,  8'd5,  16'd15};
    vecs[1] = '{8'h80, 8'h80, 16'h4000};
    vecs[2] = '{8'h5A, 8'h00, 16'h0000};
    vecs[3] = '{8'h00, 8'h7F, 16'h0000};
    vecs[4] = '{8'hFF, 8'h01, 16'hFFFF};
    vecs[5] = '{8'h7F, 8'h7F, 16'd16129};
    vecs[6] = '{8'h80, 8'h7F, 16'hC080};
    vecs[7] = '{8'hF9, 8'hFD, 16'd21};
    vecs[8] = '{8'h55, 8'hAA, 16'hE372};
    vecs[9] = '{8'h80, 8'h01, 16'hFF80};

    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    tick();
    tick();
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_product", product, 16'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
    end

    // start held high: back-to-back operations six cycles apart
    start = 1'b1;
    a = 8'h7F;
    b = 8'h80;
    tick();
    a = 8'hFF;
    b = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      chk("held_busy1", {15'd0, busy}, 16'd1);
      tick();
    end
    chk("held_done1", {15'd0, done}, 16'd1);
    chk("held_prod1", product, 16'hC080);
    tick();
    chk("held_idle", {15'd0, busy | done}, 16'd0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("held_busy2", {15'd0, busy}, 16'd1);
      tick();
    end
    chk("held_done2", {15'd0, done}, 16'd1);
    chk("held_prod2", product, 16'd1);
    tick();

    // start re-pulsed during RUN is ignored
    start = 1'b1;
    a = 8'd12;
    b = 8'hF6;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    a = 8'd100;
    b = 8'd100;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("ign_done", {15'd0, done}, 16'd1);
    chk("ign_product", product, 16'hFF88);
    tick();
    chk("ign_no_restart", {15'd0, busy | done}, 16'd0);
    tick();

    // reset in the middle of an operation (j=2)
    start = 1'b1;
    a = 8'd9;
    b = 8'd9;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {15'd0, busy}, 16'd0);
    chk("mid_rst_product", product, 16'd0);
    chk("mid_rst_done", {15'd0, done}, 16'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_quiet", {15'd0, busy | done}, 16'd0);
    end

    // random sweep
    for (int i = 0; i < 1500; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rexp = ra * rb;
      run_op(ra, rb, rexp, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
